// File: rtl/dcache_pkg.sv
// Shared types and helpers for the direct-mapped write-through data cache.
// Provides the controller FSM state enum and an address field slicer.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REFILL,
    WRITE
  } state_t;

  // Extracts a w-bit field starting at bit lsb (zero-extended to 32 bits).
  function automatic logic [31:0] field(
    input logic [31:0] a,
    input int          lsb,
    input int          w
  );
    logic [31:0] m;
    m = (32'd1 << w) - 32'd1;
    return (a >> lsb) & m;
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Tag/valid/data storage: combinational read, full-line fill, byte-masked
// word merge and flash invalidate. Ports: clk, rst_n, idx, rd_*, line/word wr, inv.
module dcache_array #(
  parameter int IDX_W = 3,
  parameter int OFF_W = 2,
  parameter int TAG_W = 7
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [IDX_W-1:0]         idx,
  output logic                     rd_valid,
  output logic [TAG_W-1:0]         rd_tag,
  output logic [(32<<OFF_W)-1:0]   rd_line,
  input  logic                     line_we,
  input  logic [TAG_W-1:0]         wr_tag,
  input  logic [(32<<OFF_W)-1:0]   wr_line,
  input  logic                     word_we,
  input  logic [OFF_W-1:0]         word_off,
  input  logic [3:0]               word_be,
  input  logic [31:0]              word_data,
  input  logic                     inv
);

  localparam int NLINES = 1 << IDX_W;
  localparam int LINE_W = 32 << OFF_W;

  logic [NLINES-1:0] valid_q;
  logic [TAG_W-1:0]  tag_q  [NLINES];
  logic [LINE_W-1:0] data_q [NLINES];

  logic [31:0]       bmask;
  logic [LINE_W-1:0] wmask;
  logic [LINE_W-1:0] wdata;

  assign rd_valid = valid_q[idx];
  assign rd_tag   = tag_q[idx];
  assign rd_line  = data_q[idx];

  assign bmask = {{8{word_be[3]}}, {8{word_be[2]}},
                  {8{word_be[1]}}, {8{word_be[0]}}};
  assign wmask = LINE_W'(bmask) << {word_off, 5'd0};
  assign wdata = LINE_W'(word_data) << {word_off, 5'd0};

  // Invalidate wins over a same-edge fill: the filled line stays invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (inv) begin
      valid_q <= '0;
    end else if (line_we) begin
      valid_q[idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (line_we) begin
      tag_q[idx]  <= wr_tag;
      data_q[idx] <= wr_line;
    end else if (word_we) begin
      data_q[idx] <= (data_q[idx] & ~wmask) | (wdata & wmask);
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-through, no-write-allocate D-cache controller.
// Ports: core DMEM side, INV, MEM req/ack side; HIT_CNT/MISS_CNT if DCACHE_PERF_CNT_EN.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int IDX_W  = 3,
  parameter int OFF_W  = 2
) (
  input  logic                   CLK,
  input  logic                   RSTn,
  input  logic                   D_MEM_CSN,
  input  logic                   D_MEM_WEN,
  input  logic [ADDR_W-1:0]      D_MEM_ADDR,
  input  logic [3:0]             D_MEM_BE,
  input  logic [31:0]            D_MEM_DI,
  output logic [31:0]            Cache_DO,
  output logic                   RDY,
  output logic                   VALID,
  input  logic                   INV,
  output logic                   MEM_REQ,
  output logic                   MEM_WE,
  output logic [ADDR_W-1:0]      MEM_ADDR,
  output logic [3:0]             MEM_BE,
  output logic [31:0]            MEM_WDATA,
  input  logic [(32<<OFF_W)-1:0] MEM_RDATA,
`ifdef DCACHE_PERF_CNT_EN
  output logic [31:0]            HIT_CNT,
  output logic [31:0]            MISS_CNT,
`endif
  input  logic                   MEM_ACK
);

  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int LINE_W = 32 << OFF_W;

  state_t            state;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [3:0]        mem_be_q;
  logic [31:0]       mem_wdata_q;

  logic [31:0]       addr32;
  logic [TAG_W-1:0]  tag;
  logic [IDX_W-1:0]  idx;
  logic [OFF_W-1:0]  off;

  logic              req;
  logic              is_ld;
  logic              is_st;
  logic              hit;
  logic              ack_rf;
  logic              ack_wr;

  logic              rd_valid;
  logic [TAG_W-1:0]  rd_tag;
  logic [LINE_W-1:0] rd_line;
  logic [31:0]       hit_word;
  logic [31:0]       fill_word;

  assign addr32 = 32'(D_MEM_ADDR);
  assign off = OFF_W'(field(addr32, 0, OFF_W));
  assign idx = IDX_W'(field(addr32, OFF_W, IDX_W));
  assign tag = TAG_W'(field(addr32, OFF_W + IDX_W, TAG_W));

  // Requests are masked during reset so RDY reads 1 there.
  assign req   = RSTn & ~D_MEM_CSN;
  assign is_ld = req & D_MEM_WEN;
  assign is_st = req & ~D_MEM_WEN;

  assign hit    = rd_valid & (rd_tag == tag);
  assign ack_rf = (state == REFILL) & MEM_ACK;
  assign ack_wr = (state == WRITE) & MEM_ACK;

  assign hit_word  = rd_line[{off, 5'd0} +: 32];
  assign fill_word = MEM_RDATA[{off, 5'd0} +: 32];

  dcache_array #(
    .IDX_W (IDX_W),
    .OFF_W (OFF_W),
    .TAG_W (TAG_W)
  ) u_array (
    .clk       (CLK),
    .rst_n     (RSTn),
    .idx       (idx),
    .rd_valid  (rd_valid),
    .rd_tag    (rd_tag),
    .rd_line   (rd_line),
    .line_we   (ack_rf),
    .wr_tag    (tag),
    .wr_line   (MEM_RDATA),
    .word_we   (ack_wr & hit),
    .word_off  (off),
    .word_be   (D_MEM_BE),
    .word_data (D_MEM_DI),
    .inv       (INV)
  );

  always_comb begin
    RDY      = 1'b1;
    VALID    = 1'b0;
    Cache_DO = '0;
    unique case (1'b1)
      (state == IDLE): begin
        RDY   = ~req | (is_ld & hit);
        VALID = is_ld & hit;
        if (is_ld & hit) Cache_DO = hit_word;
      end
      (state == REFILL): begin
        // Requested word bypasses straight from the memory line.
        RDY   = MEM_ACK;
        VALID = MEM_ACK;
        if (MEM_ACK) Cache_DO = fill_word;
      end
      (state == WRITE): begin
        RDY = MEM_ACK;
      end
      default: begin
        RDY = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state       <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (is_st) begin
            state       <= WRITE;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= D_MEM_ADDR;
            mem_be_q    <= D_MEM_BE;
            mem_wdata_q <= D_MEM_DI;
          end else if (is_ld & ~hit) begin
            state      <= REFILL;
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= {tag, idx, {OFF_W{1'b0}}};
          end
        end
        REFILL: begin
          if (MEM_ACK) begin
            state     <= IDLE;
            mem_req_q <= 1'b0;
          end
        end
        WRITE: begin
          if (MEM_ACK) begin
            state     <= IDLE;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          mem_req_q <= 1'b0;
          mem_we_q  <= 1'b0;
        end
      endcase
    end
  end

  assign MEM_REQ   = mem_req_q;
  assign MEM_WE    = mem_we_q;
  assign MEM_ADDR  = mem_addr_q;
  assign MEM_BE    = mem_be_q;
  assign MEM_WDATA = mem_wdata_q;

`ifdef DCACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if ((state == IDLE) && is_ld && hit && (hit_cnt_q != '1))
        hit_cnt_q <= hit_cnt_q + 32'd1;
      if (ack_rf && (miss_cnt_q != '1))
        miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign HIT_CNT  = hit_cnt_q;
  assign MISS_CNT = miss_cnt_q;
`endif

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Parametrised direct-mapped, write-through, no-write-allocate data cache between the RISC-V core's DMEM port and a slower backing data memory.
- Hits are served combinationally in the same cycle; misses and stores stall the pipeline via RDY.
- A line-refill FSM talks to memory over a req/ack handshake.
- Successor to the fixed 8-line/4-word cache: geometry, memory latency tolerance and invalidate are all new.

Parameters:
- ADDR_W, 12, CPU word-address width
- IDX_W, 3, index bits; number of lines = 2**IDX_W
- OFF_W, 2, word-offset bits; words per line = 2**OFF_W
- TAG_W, ADDR_W-IDX_W-OFF_W, tag width (derived localparam)

Ports:
- CLK  in  1  clock, all state on rising edge
- RSTn  in  1  asynchronous active-low reset
- D_MEM_CSN  in  1  active-low access request from core
- D_MEM_WEN  in  1  active-low write enable (0 = store)
- D_MEM_ADDR  in  ADDR_W  word address
- D_MEM_BE  in  4  byte enables for store
- D_MEM_DI  in  32  store data
- Cache_DO  out  32  load data to core
- RDY  out  1  1 = access completes this cycle; 0 = stall
- VALID  out  1  Cache_DO holds valid load data this cycle
- INV  in  1  one-cycle pulse, invalidate all lines
- MEM_REQ  out  1  memory request, held until MEM_ACK
- MEM_WE  out  1  1 = write-through word, 0 = line read
- MEM_ADDR  out  ADDR_W  word address; low OFF_W bits zero for line reads
- MEM_BE  out  4  byte enables for writes
- MEM_WDATA  out  32  write data
- MEM_RDATA  in  32*2**OFF_W  full line, valid with MEM_ACK
- MEM_ACK  in  1  one-cycle completion strobe

Behaviour:
- Reset: all valid bits 0, state IDLE, MEM_REQ=0, MEM_WE=0, RDY=1, VALID=0, Cache_DO=0. Reset mid-refill or mid-write abandons the transaction; no line is written.
- Idle, no request (CSN=1): RDY=1, VALID=0.
- IDLE, load hit (valid && tag match): RDY=1, VALID=1, Cache_DO = line word[offset], same cycle, no memory traffic.
- IDLE, load miss: RDY=0, VALID=0; next state REFILL. MEM_REQ=1 and MEM_WE=0 from the next cycle, with MEM_ADDR = {tag,idx,0}.
- REFILL: hold MEM_REQ/MEM_ADDR until MEM_ACK.
  - On the ACK cycle: write the line, tag and valid bit. Bypass the requested word, so Cache_DO = MEM_RDATA word[offset], RDY=1, VALID=1.
  - Return to IDLE.
  - Miss latency = memory latency + 1 stall cycle.
- IDLE, store (hit or miss): RDY=0; next state WRITE. MEM_REQ=1, MEM_WE=1, MEM_ADDR = D_MEM_ADDR, MEM_BE/MEM_WDATA = D_MEM_BE/D_MEM_DI.
- WRITE: on MEM_ACK set RDY=1 in that cycle.
  - If the line is a hit, merge bytes into it per BE on the same edge.
  - Misses do not allocate.
  - Return to IDLE.
- The core holds CSN/ADDR/DI stable while RDY=0. Inputs are sampled at IDLE and at the ACK cycle only.
- INV:
  - Clears all valid bits on the next edge, in any state.
  - If coincident with a refill ACK, the refilled line is left invalid, but the bypassed data is still returned.
  - If coincident with an IDLE hit, the hit still completes.
- MEM_ACK outside REFILL/WRITE is ignored.
- No address checks; ADDR wraps naturally.

Optional Feature:
- Macro DCACHE_PERF_CNT_EN adds outputs HIT_CNT[31:0] and MISS_CNT[31:0].
- Counter rules:
  - Each counter increments once per completed load hit / load miss; stores are not counted.
  - Counters saturate at 0xFFFFFFFF.
  - Counters are reset by RSTn only.
- Without the macro, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package dcache_pkg: FSM state enum (IDLE, REFILL, WRITE) and a tag/index/offset field-slicing helper.
- One sub-module, dcache_array: tag/valid/data storage with a combinational read port, a full-line write port, byte-masked word write, and flash-invalidate.

Test Plan:
- Reset, then load at addr 0x010 (miss), MEM_ACK after 3 cycles with line {W3..W0} = {4,3,2,1} → RDY low 3 cycles, ACK cycle Cache_DO=0x1; a load at 0x012 next cycle hits with Cache_DO=0x3, RDY=1, no MEM_REQ.
- Load at 0x030 (same idx as 0x010, different tag) → miss and refill; a reload at 0x010 misses again (conflict eviction).
- Store 0xAABBCCDD with BE=0b0011 to cached 0x011 → MEM_WE=1, MEM_BE=0x3; after ACK, a load at 0x011 returns 0x0000CCDD merged with old upper bytes of W1=0x2, i.e. 0x0000CCDD.
- Store to uncached 0x100 → memory write only; a subsequent load at 0x100 misses.
- INV pulse after line 0x010 is filled → the next load at 0x010 misses; INV on the refill ACK cycle → data returned, but the following load to the same line misses.
- Assert RSTn=0 mid-REFILL → MEM_REQ drops immediately, RDY=1, all lines invalid.
